// File: rtl/rv_pkg.sv
// Shared RV32 register-file types used by the writeback arbiter and its scoreboard.
package rv_pkg;
  localparam int RV_RF_WIDTH   = 5;
  localparam int RV_DATA_WIDTH = 32;

  typedef logic [RV_RF_WIDTH-1:0]   reg_addr_t;
  typedef logic [RV_DATA_WIDTH-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the writeback, M-unit, decode and register-file write-port signals
// around the write-port arbiter; master drives requests, slave is the arbiter.
interface rf_wb_arbiter_if
  import rv_pkg::*;
#(
  parameter int RF_WIDTH   = RV_RF_WIDTH,
  parameter int DATA_WIDTH = RV_DATA_WIDTH
) ();
  logic                  pipe_we;
  logic [RF_WIDTH-1:0]   pipe_rd;
  logic [DATA_WIDTH-1:0] pipe_wdata;
  logic                  wb_stall;

  logic                  md_issue;
  logic [RF_WIDTH-1:0]   md_issue_rd;
  logic                  md_valid;
  logic [RF_WIDTH-1:0]   md_rd;
  logic [DATA_WIDTH-1:0] md_wdata;
  logic                  md_ready;

  logic [RF_WIDTH-1:0]   dec_rs1;
  logic [RF_WIDTH-1:0]   dec_rs2;
  logic [RF_WIDTH-1:0]   dec_rd;
  logic                  dec_stall;

  logic                  rf_we;
  logic [RF_WIDTH-1:0]   rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport master (
    output pipe_we, pipe_rd, pipe_wdata,
    output md_issue, md_issue_rd, md_valid, md_rd, md_wdata,
    output dec_rs1, dec_rs2, dec_rd,
    input  wb_stall, md_ready, dec_stall,
    input  rf_we, rf_addr, rf_wdata
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata,
    input  md_issue, md_issue_rd, md_valid, md_rd, md_wdata,
    input  dec_rs1, dec_rs2, dec_rd,
    output wb_stall, md_ready, dec_stall,
    output rf_we, rf_addr, rf_wdata
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for in-flight M-unit results; one bit per
// architectural register, x0 never tracked, three read ports ORed into a hazard.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int RF_WIDTH = RV_RF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [RF_WIDTH-1:0] set_addr,
  input  logic                clr_en,
  input  logic [RF_WIDTH-1:0] clr_addr,
  input  logic [RF_WIDTH-1:0] rs1,
  input  logic [RF_WIDTH-1:0] rs2,
  input  logic [RF_WIDTH-1:0] rd,
  output logic                hazard
);
  localparam int NREG = 2 ** RF_WIDTH;
  localparam logic [RF_WIDTH-1:0] RZ = RF_WIDTH'(REG_ZERO);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Clear first so a same-cycle re-issue to the draining register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en && set_addr != RZ) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign hazard = (pending[rs1] && rs1 != RZ) ||
                  (pending[rs2] && rs2 != RZ) ||
                  (pending[rd]  && rd  != RZ);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and a one-entry
// M-unit result buffer, with a starvation limit that briefly stalls writeback.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int RF_WIDTH     = RV_RF_WIDTH,
  parameter int DATA_WIDTH   = RV_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]       STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [RF_WIDTH-1:0] RZ         = RF_WIDTH'(REG_ZERO);

  logic                  hold_valid;
  logic [RF_WIDTH-1:0]   hold_rd;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [SW-1:0]         starve_cnt;

  logic pipe_wr;
  logic starved;
  logic buf_grant;
  logic md_accept;
  logic hazard;

  assign pipe_wr   = bus.pipe_we && (bus.pipe_rd != RZ);
  assign starved   = (starve_cnt == STARVE_MAX);
  // Gated by rst so a buffered result is dropped rather than written during reset.
  assign buf_grant = !rst && hold_valid && (!pipe_wr || starved);
  assign md_accept = bus.md_valid && !hold_valid;

  assign bus.md_ready  = !hold_valid;
  assign bus.wb_stall  = !rst && hold_valid && starved && pipe_wr;
  assign bus.rf_we     = buf_grant ? (hold_rd != RZ) : pipe_wr;
  assign bus.rf_addr   = buf_grant ? hold_rd   : bus.pipe_rd;
  assign bus.rf_wdata  = buf_grant ? hold_data : bus.pipe_wdata;
  assign bus.dec_stall = !rst && hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (buf_grant)      hold_valid <= 1'b0;
      else if (md_accept) hold_valid <= 1'b1;

      if (!hold_valid || buf_grant) starve_cnt <= '0;
      else if (!starved)            starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (md_accept) begin
      hold_rd   <= bus.md_rd;
      hold_data <= bus.md_wdata;
    end
  end

  rf_scoreboard #(
    .RF_WIDTH (RF_WIDTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.md_issue),
    .set_addr (bus.md_issue_rd),
    .clr_en   (buf_grant),
    .clr_addr (hold_rd),
    .rs1      (bus.dec_rs1),
    .rs2      (bus.dec_rs2),
    .rd       (bus.dec_rd),
    .hazard   (hazard)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle vector table plus hand-written
// starvation and mid-operation reset sequences.
module tb_rf_wb_arbiter;
  import rv_pkg::*;

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        iss;
    logic [4:0]  ird;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_dat;
    logic        e_stall;
    logic        e_ready;
    logic        e_dec;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(
    .RF_WIDTH     (5),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Writing a register whose M-unit result is still outstanding is illegal.
  always @(negedge clk) begin
    if (!rst && bus.pipe_we && bus.pipe_rd != REG_ZERO)
      assert (!dut.u_sb.pending[bus.pipe_rd])
      else $error("FAIL illegal_pipe_write rd=%0d is pending", bus.pipe_rd);
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  function automatic vec_t v(int unsigned pwe, int unsigned prd, int unsigned pdat,
                             int unsigned iss, int unsigned ird,
                             int unsigned mv, int unsigned mrd, int unsigned mdat,
                             int unsigned rs1, int unsigned rs2, int unsigned rd,
                             int unsigned e_we, int unsigned e_addr, int unsigned e_dat,
                             int unsigned e_stall, int unsigned e_ready, int unsigned e_dec);
    vec_t r;
    r.pwe = 1'(pwe);   r.prd = 5'(prd);   r.pdat = pdat;
    r.iss = 1'(iss);   r.ird = 5'(ird);
    r.mv  = 1'(mv);    r.mrd = 5'(mrd);   r.mdat = mdat;
    r.rs1 = 5'(rs1);   r.rs2 = 5'(rs2);   r.rd = 5'(rd);
    r.e_we = 1'(e_we); r.e_addr = 5'(e_addr); r.e_dat = e_dat;
    r.e_stall = 1'(e_stall); r.e_ready = 1'(e_ready); r.e_dec = 1'(e_dec);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    bus.pipe_we     = r.pwe;
    bus.pipe_rd     = r.prd;
    bus.pipe_wdata  = r.pdat;
    bus.md_issue    = r.iss;
    bus.md_issue_rd = r.ird;
    bus.md_valid    = r.mv;
    bus.md_rd       = r.mrd;
    bus.md_wdata    = r.mdat;
    bus.dec_rs1     = r.rs1;
    bus.dec_rs2     = r.rs2;
    bus.dec_rd      = r.rd;
  endtask

  task automatic compare(vec_t r, string tag);
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(r.e_we));
    if (r.e_we) begin
      chk({tag, ".rf_addr"}, 32'(bus.rf_addr), 32'(r.e_addr));
      chk({tag, ".rf_wdata"}, bus.rf_wdata, r.e_dat);
    end
    chk({tag, ".wb_stall"}, 32'(bus.wb_stall), 32'(r.e_stall));
    chk({tag, ".md_ready"}, 32'(bus.md_ready), 32'(r.e_ready));
    chk({tag, ".dec_stall"}, 32'(bus.dec_stall), 32'(r.e_dec));
  endtask

  // One cycle: drive just after the edge, compare mid-cycle before the next edge.
  task automatic cycle(vec_t r, string tag);
    @(posedge clk);
    #1;
    drive(r);
    #3;
    compare(r, tag);
  endtask

  vec_t tbl[18];
  vec_t idle;
  int   starve_rds[5];

  initial begin
    //          pwe prd pdat          iss ird mv mrd mdat          rs1 rs2 rd  we addr dat           stl rdy dec
    tbl[0]  = v(1,  5,  32'hA5A50001, 0,  0,  0, 0,  0,            0,  0,  0,  1, 5,   32'hA5A50001, 0,  1,  0);
    tbl[1]  = v(0,  0,  0,            1,  7,  0, 0,  0,            0,  0,  0,  0, 0,   0,            0,  1,  0);
    tbl[2]  = v(0,  0,  0,            0,  0,  0, 0,  0,            7,  0,  0,  0, 0,   0,            0,  1,  1);
    tbl[3]  = v(0,  0,  0,            0,  0,  1, 7,  32'h1234,     7,  0,  0,  0, 0,   0,            0,  1,  1);
    tbl[4]  = v(0,  0,  0,            0,  0,  0, 0,  0,            7,  0,  0,  1, 7,   32'h1234,     0,  0,  1);
    tbl[5]  = v(0,  0,  0,            0,  0,  0, 0,  0,            7,  0,  0,  0, 0,   0,            0,  1,  0);
    tbl[6]  = v(0,  0,  0,            1,  10, 1, 0,  32'hDEAD,     0,  10, 0,  0, 0,   0,            0,  1,  0);
    tbl[7]  = v(0,  0,  0,            0,  0,  0, 0,  0,            0,  10, 0,  0, 0,   0,            0,  0,  1);
    tbl[8]  = v(0,  0,  0,            0,  0,  0, 0,  0,            0,  10, 0,  0, 0,   0,            0,  1,  1);
    tbl[9]  = v(1,  3,  32'h33,       0,  0,  1, 10, 32'hAA,       0,  10, 0,  1, 3,   32'h33,       0,  1,  1);
    tbl[10] = v(0,  0,  0,            0,  0,  0, 0,  0,            0,  0,  10, 1, 10,  32'hAA,       0,  0,  1);
    tbl[11] = v(0,  0,  0,            0,  0,  0, 0,  0,            0,  0,  10, 0, 0,   0,            0,  1,  0);
    tbl[12] = v(0,  0,  0,            1,  12, 0, 0,  0,            12, 0,  0,  0, 0,   0,            0,  1,  0);
    tbl[13] = v(0,  0,  0,            0,  0,  1, 12, 32'hC,        12, 0,  0,  0, 0,   0,            0,  1,  1);
    tbl[14] = v(0,  0,  0,            1,  12, 0, 0,  0,            12, 0,  0,  1, 12,  32'hC,        0,  0,  1);
    tbl[15] = v(0,  0,  0,            0,  0,  0, 0,  0,            12, 0,  0,  0, 0,   0,            0,  1,  1);
    tbl[16] = v(1,  0,  32'h77,       0,  0,  0, 0,  0,            12, 0,  0,  0, 0,   0,            0,  1,  1);
    tbl[17] = v(0,  0,  0,            0,  0,  0, 0,  0,            0,  0,  0,  0, 0,   0,            0,  1,  0);
    idle    = v(0,  0,  0,            0,  0,  0, 0,  0,            0,  0,  0,  0, 0,   0,            0,  1,  0);
    starve_rds[0] = 3; starve_rds[1] = 4; starve_rds[2] = 5; starve_rds[3] = 6; starve_rds[4] = 8;

    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset.wb_stall", 32'(bus.wb_stall), 32'd0);
    chk("reset.dec_stall", 32'(bus.dec_stall), 32'd0);
    rst = 1'b0;
    #3;
    chk("reset.md_ready", 32'(bus.md_ready), 32'd1);

    for (int i = 0; i < 18; i++) cycle(tbl[i], $sformatf("row%0d", i));

    // Buffered rd=9 competes with back-to-back pipe writes until it starves.
    cycle(v(0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 1, 0), "starve.accept");
    for (int i = 0; i < 4; i++)
      cycle(v(1, starve_rds[i], 32'h100 + starve_rds[i], 0, 0, 0, 0, 0, 0, 0, 0,
              1, starve_rds[i], 32'h100 + starve_rds[i], 0, 0, 0),
            $sformatf("starve.pipe%0d", starve_rds[i]));
    cycle(v(1, 8, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 1, 0, 0), "starve.force");
    cycle(v(1, 8, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h108, 0, 1, 0), "starve.replay");
    cycle(idle, "starve.idle");

    // Reset with the buffer full and x7 pending: nothing may be written.
    cycle(v(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rst.issue");
    cycle(v(0, 0, 0, 0, 0, 1, 7, 32'h55, 7, 0, 0, 0, 0, 0, 0, 1, 1), "rst.accept");
    @(posedge clk);
    #1;
    drive(v(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    #3;
    chk("rst.during.md_ready", 32'(bus.md_ready), 32'd0);
    chk("rst.during.rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst.during.dec_stall", 32'(bus.dec_stall), 32'd0);
    chk("rst.during.wb_stall", 32'(bus.wb_stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    compare(v(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0), "rst.after");
    cycle(v(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0), "rst.after2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the RV32IM register file. It shares the register file's single write port between the in-order pipeline writeback and the long-latency iterative multiply/divide unit. It buffers the unit's result when the port is busy and tracks destination registers still in flight. It raises a decode stall on read-after-write and write-after-write hazards against those registers. It sits between the writeback stage, the M-unit and the register file's we3/addr3/din3 inputs.

## Interface
- RF_WIDTH, 5, register address width (2**RF_WIDTH registers, x0 hard-wired zero)
- DATA_WIDTH, 32, register data width
- STARVE_LIMIT, 4, cycles a buffered M-unit result may wait before it forces the port

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  writeback stage requests a write
- pipe_rd  in  RF_WIDTH  writeback destination
- pipe_wdata  in  DATA_WIDTH  writeback data
- wb_stall  out  1  writeback stage must hold its current request this cycle
- md_issue  in  1  M-unit accepted an operation this cycle
- md_issue_rd  in  RF_WIDTH  destination of the issued operation
- md_valid  in  1  M-unit result available
- md_rd  in  RF_WIDTH  result destination
- md_wdata  in  DATA_WIDTH  result data
- md_ready  out  1  arbiter can accept a result
- dec_rs1, dec_rs2, dec_rd  in  RF_WIDTH each  decode-stage operand and destination addresses
- dec_stall  out  1  decode must stall (hazard on a pending register)
- rf_we, rf_addr, rf_wdata  out  1 / RF_WIDTH / DATA_WIDTH  register file write port (we3/addr3/din3)

## Operation
- Hold buffer: one entry {hold_valid, hold_rd, hold_data}. md_ready = !hold_valid. When md_valid && md_ready, the result is captured at posedge.
- Scoreboard: pending vector of 2**RF_WIDTH bits.
  - On md_issue with md_issue_rd != 0, bit md_issue_rd is set.
  - The bit is cleared at the posedge ending the cycle in which the buffer is granted the port.
  - If a set and a clear hit the same bit in one cycle, the set wins.
  - Bit 0 is never set.
- Port grant, evaluated combinationally each cycle:
  - The buffer is granted when hold_valid && (!pipe_we || pipe_rd == 0 || starve_cnt == STARVE_LIMIT).
  - Otherwise the pipeline is granted.
- wb_stall = hold_valid && starve_cnt == STARVE_LIMIT && pipe_we && pipe_rd != 0. While stalled, the pipeline re-presents the same request the next cycle.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments while hold_valid and the buffer is not granted.
  - Zeroed on grant or when the buffer is empty.
  - Saturates at STARVE_LIMIT.
- rf_we is asserted only for a granted write with rd != 0. A buffered result to x0 drains silently and frees the buffer.
- dec_stall = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd], with index 0 masked. There is no forwarding from the buffer.
- A pipe write to a pending rd is illegal because decode prevents it. The bench flags it with an assertion; the hardware gives it no defined priority.

## Timing
- Reset (rst=1 at posedge): hold_valid=0, pending=0, starve_cnt=0.
- During and after reset: rf_we=0 unless pipe_we, wb_stall=0, dec_stall=0, md_ready=1 from the first cycle after reset.
- A reset mid-operation discards the buffer and the scoreboard. The M-unit must be reset by the same rst.
- The pipeline write path is zero-latency: pipe_* appear on rf_* in the same cycle, and the register file commits at negedge.
- M-unit result accepted in cycle N:
  - Buffered from N+1.
  - Earliest register-file write is the negedge of N+1.
  - The pending bit clears at the posedge ending N+1.
  - dec_stall drops in N+2.
- Worst case, the buffered write occurs in cycle N+1+STARVE_LIMIT.
- A new result can be accepted in the cycle after the buffer drains. md_ready is low for at least one cycle per result; there is no same-cycle refill.

## Structure
- Shared package rv_pkg: typedefs reg_addr_t and word_t, constant REG_ZERO = 0.
- One sub-module, rf_scoreboard: the pending vector with set, clear and three read ports that produce the hazard flag.
- Arbitration, the buffer and the starvation counter live in rf_wb_arbiter.

## Test plan
- Idle M-unit, pipe_we=1, pipe_rd=5, data 0xA5A5_0001 → rf_we=1, rf_addr=5, same cycle; wb_stall=0.
- md_issue rd=7, then dec_rs1=7 → dec_stall=1 until md_valid (rd=7, 0x1234) is buffered and written; dec_stall=0 two cycles after acceptance.
- Buffer holds rd=9 while pipe_we=1 for rd=3,4,5,6,8 on consecutive cycles → pipe writes for four cycles, then wb_stall=1 and rf_addr=9; the rd=8 write lands the following cycle.
- md_valid to rd=0 with pipe idle → rf_we=0; md_ready returns to 1 one cycle later; scoreboard is unchanged.
- md_issue rd=12 in the same cycle the buffer writes rd=12 → pending[12] stays 1.
- Assert rst with the buffer full and pending[7]=1 → the next cycle shows md_ready=1, dec_stall=0 for rs1=7, and no write issued.
